// File: rtl/pe_pkg.sv
// -----------------------------------------------------------------------------
// pe_pkg
// Shared definitions for the weight-stationary processing element.
//   - pe_widths_ok : elaboration-time width legality check (ACC_W >= 2*DATA_W)
//   - pe_max_fn / pe_min_fn : saturation bounds of an ACC_W-bit sum
//   - sat_fn : clamps a wide sum into the ACC_W range and flags overflow
// Sums are carried in a fixed wide signed container (PE_WIDE_W+1 bits) so the
// helpers work for any legal ACC_W without a parameterised package.
// -----------------------------------------------------------------------------
package pe_pkg;

    localparam int PE_WIDE_W = 64;

    typedef logic signed [PE_WIDE_W:0] pe_wide_t;

    typedef struct packed {
        logic [PE_WIDE_W-1:0] val;
        logic                 ovf;
    } pe_sat_t;

    // Legal widths: product fits in the accumulator, accumulator fits in the
    // wide container with room for the extra carry bit.
    function automatic bit pe_widths_ok(input int data_w, input int acc_w);
        return (data_w > 0) && (acc_w >= 2 * data_w) && (acc_w < PE_WIDE_W);
    endfunction

    // Largest representable ACC_W value.
    function automatic pe_wide_t pe_max_fn(input int acc_w, input bit is_signed);
        pe_wide_t one;
        one = pe_wide_t'(1);
        if (is_signed) begin
            return (one <<< (acc_w - 1)) - one;
        end
        return (one <<< acc_w) - one;
    endfunction

    // Smallest representable ACC_W value.
    function automatic pe_wide_t pe_min_fn(input int acc_w, input bit is_signed);
        pe_wide_t one;
        one = pe_wide_t'(1);
        if (is_signed) begin
            return -(one <<< (acc_w - 1));
        end
        return '0;
    endfunction

    // Clamp sum into the ACC_W range; ovf reports that clamping was needed.
    function automatic pe_sat_t sat_fn(input pe_wide_t sum, input int acc_w,
                                       input bit is_signed);
        pe_sat_t  res;
        pe_wide_t hi;
        pe_wide_t lo;
        hi      = pe_max_fn(acc_w, is_signed);
        lo      = pe_min_fn(acc_w, is_signed);
        res.val = sum[PE_WIDE_W-1:0];
        res.ovf = 1'b0;
        if (sum > hi) begin
            res.val = hi[PE_WIDE_W-1:0];
            res.ovf = 1'b1;
        end else if (sum < lo) begin
            res.val = lo[PE_WIDE_W-1:0];
            res.ovf = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/pe_ws_mac_sat.sv
// -----------------------------------------------------------------------------
// pe_mac_sat
// Combinational extend / multiply / add / saturate stage of the PE.
// Ports:
//   a_i       DATA_W  activation
//   w_i       DATA_W  active weight
//   acc_i     ACC_W   incoming partial sum
//   acc_vld_i 1       partial sum valid (0 = add nothing)
//   result_o  ACC_W   wrapped or saturated sum
//   ovf_o     1       ACC_W+1-bit sum fell outside the ACC_W range
// -----------------------------------------------------------------------------
module pe_mac_sat
    import pe_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16,
    parameter int SIGNED = 0,
    parameter int SAT    = 0
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] w_i,
    input  logic [ACC_W-1:0]  acc_i,
    input  logic              acc_vld_i,
    output logic [ACC_W-1:0]  result_o,
    output logic              ovf_o
);

    localparam int XW = ACC_W + 1;

    logic [XW-1:0] a_x;
    logic [XW-1:0] w_x;
    logic [XW-1:0] acc_x;
    logic [XW-1:0] prod;
    logic [XW-1:0] sum;
    logic          sum_sgn;
    pe_wide_t      sum_w;
    pe_sat_t       sat;

    always_comb begin
        a_x   = {{(XW-DATA_W){(SIGNED != 0) & a_i[DATA_W-1]}}, a_i};
        w_x   = {{(XW-DATA_W){(SIGNED != 0) & w_i[DATA_W-1]}}, w_i};
        acc_x = {(SIGNED != 0) & acc_i[ACC_W-1], acc_i};
        // Both operands are extended to ACC_W+1 bits, so the truncated product
        // is exact: the full product always fits since ACC_W >= 2*DATA_W.
        prod  = a_x * w_x;
        sum   = prod + (acc_vld_i ? acc_x : '0);
        // The ACC_W+1-bit sum cannot overflow itself; interpret it per SIGNED.
        sum_sgn = (SIGNED != 0) & sum[ACC_W];
        sum_w   = pe_wide_t'({{(PE_WIDE_W-ACC_W){sum_sgn}}, sum});
        sat     = sat_fn(sum_w, ACC_W, SIGNED != 0);
        result_o = (SAT != 0) ? sat.val[ACC_W-1:0] : sum[ACC_W-1:0];
        ovf_o    = sat.ovf;
    end

endmodule

// File: rtl/pe_ws.sv
// -----------------------------------------------------------------------------
// pe_ws
// Weight-stationary systolic processing element with a double-buffered weight
// (shadow loaded through a daisy chain, active used for compute).
// Ports:
//   clk, rst                     clock, async active-high reset
//   en                           global advance; 0 holds every register
//   left_i/left_vld_i            activation in  -> right_o/right_vld_o
//   up_i/up_vld_i                partial sum in -> down_o/down_vld_o
//   w_i/w_vld_i -> w_o/w_vld_o   weight shift chain (w_o = previous shadow)
//   w_swap_i -> w_swap_o         shadow->active swap, forwarded one row/cycle
//   clr_ovf_i, ovf_o             sticky overflow flag and its clear
// -----------------------------------------------------------------------------
module pe_ws
    import pe_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16,
    parameter int SIGNED = 0,
    parameter int SAT    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] left_i,
    input  logic              left_vld_i,
    input  logic [ACC_W-1:0]  up_i,
    input  logic              up_vld_i,
    output logic [DATA_W-1:0] right_o,
    output logic              right_vld_o,
    output logic [ACC_W-1:0]  down_o,
    output logic              down_vld_o,
    input  logic [DATA_W-1:0] w_i,
    input  logic              w_vld_i,
    output logic [DATA_W-1:0] w_o,
    output logic              w_vld_o,
    input  logic              w_swap_i,
    output logic              w_swap_o,
    input  logic              clr_ovf_i,
    output logic              ovf_o
);

    if (!pe_widths_ok(DATA_W, ACC_W)) begin : g_bad_widths
        $error("pe_ws: illegal widths, need ACC_W >= 2*DATA_W and ACC_W < %0d",
               PE_WIDE_W);
    end

    logic [DATA_W-1:0] right_q,  right_d;
    logic              rvld_q,   rvld_d;
    logic [ACC_W-1:0]  down_q,   down_d;
    logic              dvld_q,   dvld_d;
    logic [DATA_W-1:0] wout_q,   wout_d;
    logic              wvld_q,   wvld_d;
    logic              swap_q,   swap_d;
    logic              ovf_q,    ovf_d;
    logic [DATA_W-1:0] shadow_q, shadow_d;
    logic [DATA_W-1:0] active_q, active_d;

    logic [ACC_W-1:0]  mac_result;
    logic              mac_ovf;

    // Compute always sees the registered active weight, so a swap in the
    // same cycle only takes effect on the following compute.
    pe_mac_sat #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .SIGNED (SIGNED),
        .SAT    (SAT)
    ) u_mac (
        .a_i       (left_i),
        .w_i       (active_q),
        .acc_i     (up_i),
        .acc_vld_i (up_vld_i),
        .result_o  (mac_result),
        .ovf_o     (mac_ovf)
    );

    always_comb begin
        right_d  = right_q;
        rvld_d   = left_vld_i;
        down_d   = down_q;
        dvld_d   = left_vld_i;
        wout_d   = wout_q;
        wvld_d   = w_vld_i;
        swap_d   = w_swap_i;
        ovf_d    = ovf_q;
        shadow_d = shadow_q;
        active_d = active_q;

        if (left_vld_i) begin
            right_d = left_i;
            down_d  = mac_result;
        end

        // Set has priority over clear.
        if (left_vld_i && mac_ovf) begin
            ovf_d = 1'b1;
        end else if (clr_ovf_i) begin
            ovf_d = 1'b0;
        end

        if (w_vld_i) begin
            wout_d   = shadow_q;
            shadow_d = w_i;
        end

        // Uses the pre-shift shadow when a shift happens in the same cycle.
        if (w_swap_i) begin
            active_d = shadow_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            right_q  <= '0;
            rvld_q   <= 1'b0;
            down_q   <= '0;
            dvld_q   <= 1'b0;
            wout_q   <= '0;
            wvld_q   <= 1'b0;
            swap_q   <= 1'b0;
            ovf_q    <= 1'b0;
            shadow_q <= '0;
            active_q <= '0;
        end else if (en) begin
            right_q  <= right_d;
            rvld_q   <= rvld_d;
            down_q   <= down_d;
            dvld_q   <= dvld_d;
            wout_q   <= wout_d;
            wvld_q   <= wvld_d;
            swap_q   <= swap_d;
            ovf_q    <= ovf_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    assign right_o     = right_q;
    assign right_vld_o = rvld_q;
    assign down_o      = down_q;
    assign down_vld_o  = dvld_q;
    assign w_o         = wout_q;
    assign w_vld_o     = wvld_q;
    assign w_swap_o    = swap_q;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_pe_ws.sv
// Directed-vector bench for pe_ws. Three instances share all inputs:
//   0 = unsigned/wrap, 1 = signed/saturate, 2 = signed/wrap.
module tb_pe_ws;

  localparam int DW  = 8;
  localparam int AW  = 16;
  localparam int UNS = 0;
  localparam int SS  = 1;
  localparam int SW  = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          en = 1'b0;
  logic [DW-1:0] left_i = '0;
  logic          left_vld_i = 1'b0;
  logic [AW-1:0] up_i = '0;
  logic          up_vld_i = 1'b0;
  logic [DW-1:0] w_i = '0;
  logic          w_vld_i = 1'b0;
  logic          w_swap_i = 1'b0;
  logic          clr_ovf_i = 1'b0;

  logic [DW-1:0] right_o     [3];
  logic          right_vld_o [3];
  logic [AW-1:0] down_o      [3];
  logic          down_vld_o  [3];
  logic [DW-1:0] w_o         [3];
  logic          w_vld_o     [3];
  logic          w_swap_o    [3];
  logic          ovf_o       [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    pe_ws #(
      .DATA_W (DW),
      .ACC_W  (AW),
      .SIGNED ((g == 0) ? 0 : 1),
      .SAT    ((g == 1) ? 1 : 0)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .left_i      (left_i),
      .left_vld_i  (left_vld_i),
      .up_i        (up_i),
      .up_vld_i    (up_vld_i),
      .right_o     (right_o[g]),
      .right_vld_o (right_vld_o[g]),
      .down_o      (down_o[g]),
      .down_vld_o  (down_vld_o[g]),
      .w_i         (w_i),
      .w_vld_i     (w_vld_i),
      .w_o         (w_o[g]),
      .w_vld_o     (w_vld_o[g]),
      .w_swap_i    (w_swap_i),
      .w_swap_o    (w_swap_o[g]),
      .clr_ovf_i   (clr_ovf_i),
      .ovf_o       (ovf_o[g])
    );
  end

  int n_vec = 0;
  int n_miscmp = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_weight(input logic [DW-1:0] w);
    w_vld_i = 1'b1;
    w_i     = w;
    tick();
    w_vld_i  = 1'b0;
    w_swap_i = 1'b1;
    tick();
    w_swap_i = 1'b0;
  endtask

  task automatic drive_mac(input logic [DW-1:0] a, input logic [AW-1:0] p, input logic pv);
    left_i     = a;
    left_vld_i = 1'b1;
    up_i       = p;
    up_vld_i   = pv;
  endtask

  initial begin
    // reset state
    #12;
    check("rst_right",     right_o[UNS],     0);
    check("rst_right_vld", right_vld_o[UNS], 0);
    check("rst_down",      down_o[UNS],      0);
    check("rst_down_vld",  down_vld_o[UNS],  0);
    check("rst_w_o",       w_o[UNS],         0);
    check("rst_w_vld",     w_vld_o[UNS],     0);
    check("rst_swap",      w_swap_o[UNS],    0);
    check("rst_ovf",       ovf_o[SS],        0);
    rst = 1'b0;
    en  = 1'b1;
    tick();

    // unsigned compute: 20*10+100, then without up
    load_weight(8'd10);
    drive_mac(8'd20, 16'd100, 1'b1);
    tick();
    check("u_down",      down_o[UNS],      16'd300);
    check("u_right",     right_o[UNS],     8'd20);
    check("u_down_vld",  down_vld_o[UNS],  1);
    check("u_right_vld", right_vld_o[UNS], 1);
    up_vld_i = 1'b0;
    tick();
    check("u_down_noup", down_o[UNS], 16'd200);
    left_vld_i = 1'b0;
    tick();
    check("u_vld_drop",  down_vld_o[UNS], 0);
    check("u_down_hold", down_o[UNS],     16'd200);

    // signed compute: -3*7+5 = -16
    load_weight(8'hFD);
    drive_mac(8'd7, 16'd5, 1'b1);
    tick();
    check("s_down_sat",  down_o[SS], 16'hFFF0);
    check("s_down_wrap", down_o[SW], 16'hFFF0);
    check("s_no_ovf",    ovf_o[SS],  0);
    left_vld_i = 1'b0;

    // overflow: 127*127+32767 = 48896
    load_weight(8'd127);
    drive_mac(8'd127, 16'h7FFF, 1'b1);
    tick();
    check("sat_down",   down_o[SS],  16'h7FFF);
    check("sat_ovf",    ovf_o[SS],   1);
    check("wrap_down",  down_o[SW],  16'hBF00);
    check("wrap_ovf",   ovf_o[SW],   1);
    check("uns_down",   down_o[UNS], 16'hBF00);
    check("uns_no_ovf", ovf_o[UNS],  0);
    left_vld_i = 1'b0;
    repeat (10) tick();
    check("ovf_sticky",    ovf_o[SS],      1);
    check("sat_down_hold", down_o[SS],     16'h7FFF);
    check("sat_vld_drop",  down_vld_o[SS], 0);
    clr_ovf_i = 1'b1;
    tick();
    check("ovf_clr_sat",  ovf_o[SS], 0);
    check("ovf_clr_wrap", ovf_o[SW], 0);
    drive_mac(8'd127, 16'h7FFF, 1'b1);
    tick();
    check("ovf_set_wins", ovf_o[SS], 1);
    left_vld_i = 1'b0;
    tick();
    check("ovf_clr_again", ovf_o[SS], 0);
    clr_ovf_i = 1'b0;

    // weight chain from a clean state
    rst = 1'b1;
    #1;
    rst = 1'b0;
    w_vld_i = 1'b1;
    w_i     = 8'd3;
    tick();
    check("chain1_w_o", w_o[UNS],     0);
    check("chain1_vld", w_vld_o[UNS], 1);
    w_i = 8'd5;
    tick();
    check("chain2_w_o", w_o[UNS],     8'd3);
    check("chain2_vld", w_vld_o[UNS], 1);
    w_vld_i = 1'b0;
    tick();
    check("chain_vld_drop", w_vld_o[UNS], 0);
    check("chain_w_o_hold", w_o[UNS],     8'd3);
    w_swap_i = 1'b1;
    tick();
    check("swap_pulse", w_swap_o[UNS], 1);
    w_swap_i = 1'b0;
    drive_mac(8'd1, 16'd0, 1'b1);
    tick();
    check("swap_end",   w_swap_o[UNS], 0);
    check("shadow_is5", down_o[UNS],   16'd5);
    left_vld_i = 1'b0;

    // swap/compute overlap
    load_weight(8'd2);
    w_vld_i = 1'b1;
    w_i     = 8'd9;
    tick();
    w_vld_i  = 1'b0;
    w_swap_i = 1'b1;
    drive_mac(8'd1, 16'd0, 1'b1);
    tick();
    check("ovl_old_w", down_o[UNS], 16'd2);
    w_swap_i = 1'b0;
    tick();
    check("ovl_new_w", down_o[UNS], 16'd9);
    left_vld_i = 1'b0;

    // same sequence with a 3-cycle stall in the middle
    load_weight(8'd2);
    w_vld_i = 1'b1;
    w_i     = 8'd9;
    tick();
    w_vld_i  = 1'b0;
    w_swap_i = 1'b1;
    drive_mac(8'd1, 16'd0, 1'b1);
    tick();
    check("stl_old_w", down_o[UNS], 16'd2);
    en       = 1'b0;
    w_swap_i = 1'b0;
    drive_mac(8'd5, 16'h77, 1'b1);
    w_vld_i  = 1'b1;
    w_i      = 8'h55;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stl_down",     down_o[UNS],      16'd2);
      check("stl_down_vld", down_vld_o[UNS],  1);
      check("stl_right",    right_o[UNS],     8'd1);
      check("stl_swap",     w_swap_o[UNS],    1);
      check("stl_w_o",      w_o[UNS],         8'd2);
      check("stl_w_vld",    w_vld_o[UNS],     0);
    end
    en      = 1'b1;
    w_vld_i = 1'b0;
    drive_mac(8'd1, 16'd0, 1'b1);
    tick();
    check("stl_new_w", down_o[UNS],   16'd9);
    check("stl_swap0", w_swap_o[UNS], 0);
    left_vld_i = 1'b0;

    // swap and shift in the same cycle
    load_weight(8'd2);
    w_vld_i = 1'b1;
    w_i     = 8'd6;
    tick();
    w_i      = 8'd11;
    w_swap_i = 1'b1;
    tick();
    check("ss_w_o", w_o[UNS], 8'd6);
    w_vld_i  = 1'b0;
    w_swap_i = 1'b0;
    drive_mac(8'd1, 16'd0, 1'b1);
    tick();
    check("ss_active", down_o[UNS], 16'd6);
    w_swap_i = 1'b1;
    tick();
    check("ss_swap_old", down_o[UNS], 16'd6);
    w_swap_i = 1'b0;
    tick();
    check("ss_shadow", down_o[UNS], 16'd11);
    left_vld_i = 1'b0;

    // async reset mid-stream
    load_weight(8'd127);
    drive_mac(8'd127, 16'h7FFF, 1'b1);
    tick();
    check("pre_rst_ovf", ovf_o[SS], 1);
    #3;
    rst = 1'b1;
    #1;
    check("arst_down",      down_o[UNS],      0);
    check("arst_down_vld",  down_vld_o[UNS],  0);
    check("arst_right",     right_o[UNS],     0);
    check("arst_right_vld", right_vld_o[UNS], 0);
    check("arst_w_o",       w_o[UNS],         0);
    check("arst_ovf",       ovf_o[SS],        0);
    rst = 1'b0;
    drive_mac(8'd33, 16'd1234, 1'b1);
    tick();
    check("post_rst_u",  down_o[UNS], 16'd1234);
    check("post_rst_ss", down_o[SS],  16'd1234);
    left_vld_i = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule

// File: doc/pe_ws.md
# pe_ws

Parametrised weight-stationary systolic processing element, the next-generation building block for the NxN systolic array. It generalises the original 8/16-bit PE:
- data and accumulator widths are parameters
- signed or unsigned operation, wrap or saturate
- valid bits travel alongside the data
- a double-buffered weight register with a daisy-chained shadow-load path, so the next weight tile loads while the current tile computes

One instance sits at every array coordinate. Activations flow left→right, partial sums flow top→bottom, and weights shift top→bottom.

## Interface
Parameters:
- DATA_W, 8, activation/weight width
- ACC_W, 16, partial-sum width; must satisfy ACC_W ≥ 2*DATA_W
- SIGNED, 0, 1 = two's-complement operands and sums; 0 = unsigned
- SAT, 0, 1 = saturate the sum to the ACC_W range; 0 = wrap modulo 2^ACC_W

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- en  in  1  global advance; 0 stalls every register in the PE
- left_i  in  DATA_W  activation in
- left_vld_i  in  1  activation valid
- up_i  in  ACC_W  partial sum in
- up_vld_i  in  1  partial-sum valid
- right_o  out  DATA_W  registered activation out
- right_vld_o  out  1  registered activation valid
- down_o  out  ACC_W  registered partial sum out
- down_vld_o  out  1  registered partial-sum valid
- w_i  in  DATA_W  weight shift-chain in
- w_vld_i  in  1  shift strobe
- w_o  out  DATA_W  weight shift-chain out (previous shadow value)
- w_vld_o  out  1  shift strobe out
- w_swap_i  in  1  copy shadow weight into active weight
- w_swap_o  out  1  w_swap_i delayed one cycle
- clr_ovf_i  in  1  clear the sticky overflow flag
- ovf_o  out  1  sticky saturation/overflow flag

## Operation
- Reset clears every register to 0: right_o, right_vld_o, down_o, down_vld_o, w_o, w_vld_o, w_swap_o, ovf_o, shadow weight, active weight.
- The actions below apply only on cycles with en=1. When en=0, every register holds, including the weight chain, swap pipe and ovf_o.
- Compute, when left_vld_i=1:
  - sum = ext(left_i)*ext(w_act) + (up_vld_i ? ext(up_i) : 0)
  - ext is sign-extension when SIGNED=1, zero-extension otherwise.
  - The sum is computed at ACC_W+1 bits, then wrapped or saturated to ACC_W per SAT.
  - down_o←result, down_vld_o←1, right_o←left_i, right_vld_o←1.
- When left_vld_i=0: right_vld_o←0 and down_vld_o←0. right_o and down_o hold.
- Overflow is when the ACC_W+1 result lies outside the ACC_W range:
  - SIGNED=1: range is [-2^(ACC_W-1), 2^(ACC_W-1)-1]
  - SIGNED=0: range is [0, 2^ACC_W-1]
  - On overflow, SAT=1 clamps to the nearest bound; SAT=0 keeps the low ACC_W bits.
  - In both cases ovf_o←1 and stays set until clr_ovf_i.
  - If clr_ovf_i and a new overflow occur in the same cycle, set wins.
- Weight shift: on w_vld_i=1, w_o←shadow, w_vld_o←1, shadow←w_i. On w_vld_i=0, w_vld_o←0 and w_o holds. A column of R PEs is loaded by R strobes, bottom row's weight first.
- Swap: on w_swap_i=1, active←shadow. w_swap_o←w_swap_i on every advancing cycle, so the swap wavefront tracks the one-row skew of the partial sums.
- Simultaneous events:
  - Compute and swap in the same cycle: compute uses the old active weight.
  - Swap and shift in the same cycle: active takes the old shadow, shadow takes w_i.

## Timing
- Compute latency: 1 cycle from left_i/up_i to down_o/right_o. Throughput is one MAC per cycle.
- Weight shift: 1 cycle per hop. Swap propagation: 1 cycle per row.
- The new active weight first affects the compute on the cycle after the swap.
- rst asserts outputs asynchronously. Deassertion is synchronised externally. A reset mid-operation discards both weights.
- The multiply-add is a single combinational stage. It must close timing at DATA_W=8, ACC_W=32.

## Structure
- Package pe_pkg:
  - the ACC_W ≥ 2*DATA_W elaboration check
  - the saturation bound constants
  - sat_fn(sum, SIGNED) returning the clamped value and an overflow bit
- Sub-module pe_mac_sat: combinational extend/multiply/add/saturate, with outputs result and ovf.
- pe_ws holds all registers.

## Test plan
Tests use DATA_W=8, ACC_W=16.
- Unsigned compute (SIGNED=0): w_act=10, left_i=20, up_i=100, both valids 1 → next cycle down_o=300, right_o=20, both valids 1. up_vld_i=0 with the same inputs → down_o=200.
- Signed compute (SIGNED=1): w_act=8'hFD (-3), left_i=7, up_i=5 → down_o=16'hFFF0. No overflow.
- Saturation and wrap (SIGNED=1): w=127, left=127, up=16'h7FFF.
  - SAT=1 → down_o=16'h7FFF, ovf_o=1, held for 10 cycles, cleared one cycle after clr_ovf_i.
  - SAT=0 → down_o=16'hBF00, ovf_o=1.
- Weight chain: strobe w_i=3 then 5 → after strobe 1, shadow=3 and w_o=0; after strobe 2, w_o=3, w_vld_o=1, shadow=5. A w_swap_i pulse → w_swap_o pulses the next cycle.
- Swap/compute overlap: active=2, shadow=9, swap with left=1, up=0 → down_o=2. Next cycle left=1 → down_o=9. Repeat with en=0 for 3 cycles mid-sequence → all outputs frozen, then resume identically.
- Async reset: assert rst between clock edges mid-stream → all outputs 0 immediately. After release, compute with w_act=0 gives down_o=up_i.
